// File: rtl/counter_pkg.sv
// Shared encodings for the general-purpose mode counter.
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage : counter_pkg

// File: rtl/mode_counter.sv
// Programmable-modulus up/down counter with wrap, saturate and one-shot modes.
// Priority each cycle: reset > load > start > step.
module mode_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VALUE = (2 ** WIDTH) - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             at_term,
   output logic             wrap,
   output logic             busy,
   output logic             done
);

   if (WIDTH < 1 || MAX_VALUE < 1 ||
       64'(MAX_VALUE) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_param
      $error("mode_counter: MAX_VALUE must lie in 1 .. 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VALUE);

   logic [WIDTH-1:0] count_q;
   state_e           state_q;
   logic             wrap_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] origin_val;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_sat;
   logic             term_hit;
   mode_e            mode_sel;

   // Terminal/origin follow the current direction; steps only happen off-terminal, so no overflow.
   always_comb begin
      mode_sel   = mode_e'(mode);
      term_val   = dir ? MAX_Q : '0;
      origin_val = dir ? '0 : MAX_Q;
      term_hit   = (count_q == term_val);
      step_val   = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      load_sat   = (load_value > MAX_Q) ? MAX_Q : load_value;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         state_q <= ST_IDLE;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         done_q <= 1'b0;

         if (load) begin
            count_q <= load_sat;
         end else if (mode_sel == MODE_ONESHOT) begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     count_q <= origin_val;
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (clk_enable) begin
                     if (term_hit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        count_q <= step_val;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end else if (clk_enable) begin
            // Reserved mode falls through to wrap behaviour.
            if (!term_hit) begin
               count_q <= step_val;
            end else if (mode_sel != MODE_SAT) begin
               count_q <= origin_val;
               wrap_q  <= 1'b1;
            end
         end

         // Leaving one-shot aborts any run silently; q is left alone.
         if (mode_sel != MODE_ONESHOT) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   assign q       = count_q;
   assign at_term = term_hit;
   assign wrap    = wrap_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule : mode_counter
